pueo_trig_accept: RTL and testbench
===================================

PUEO_TRIG_ACCEPT -- requirements
Module: pueo_trig_accept

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning the number of event entries buffered; power of 2, at least 4.
REQ-002 Parameter HOLDOFF_BITS, default 16, meaning the width of the holdoff length and counter.
REQ-003 clk_i  in  1  the single system clock; all logic is synchronous to it.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 ce_i  in  1  sysclk_x2 clock enable; marks trigger-domain cycles.
REQ-006 run_i  in  1  run enable; low = no acceptance.
REQ-007 trig_i  in  1  L2 master trigger; ce-qualified single-cycle pulse.
REQ-008 tio0_meta_i .. tio3_meta_i  in  64 each  per-TURFIO metadata, time-aligned with trig_i.
REQ-009 holdoff_len_i  in  HOLDOFF_BITS  holdoff duration, in ce cycles.
REQ-010 holdoff_o  out  1  holdoff feedback to the L2 trigger.
REQ-011 dead_o  out  1  buffer-nearly-full feedback to the L2 trigger.
REQ-012 m_evt_tdata_o  out  320  event word {evnum[31:0], trigtime[31:0], tio3, tio2, tio1, tio0 meta}; tio0 is at bits [63:0].
REQ-013 m_evt_tvalid_o  out  1  stream valid.
REQ-014 m_evt_tready_i  in  1  stream ready.
REQ-015 dropped_o  out  16  count of triggers dropped because the buffer was full; saturating.

Function
REQ-016 Trigger time counter: 32-bit; increments on every ce_i cycle; wraps at 2^32-1 to 0; cleared on a run_i rising edge.
REQ-017 Event number counter: 32-bit; cleared on a run_i rising edge; increments by 1 per accepted trigger; wraps to 0.
REQ-018 Acceptance condition: trig_i=1 AND ce_i=1 AND run_i=1 AND buffer not full.
REQ-019 On an accepted trigger, the following are written into the FIFO in that cycle:
- the current event number,
- the current trigger time,
- the four meta inputs.
REQ-020 trig_i=1 while run_i=0 is ignored and is not counted as dropped.
REQ-021 trig_i=1 with run_i=1 while the buffer is full: no write; dropped_o increments, saturating at 0xFFFF; the event number does not advance.
REQ-022 Holdoff counter:
- loaded with holdoff_len_i on each accepted trigger;
- otherwise decrements by 1 on ce_i cycles while nonzero.
REQ-023 holdoff_o is registered and high while the holdoff counter is nonzero OR run_i=0.
- After an accepted trigger with holdoff_len_i=N>0, holdoff_o is high from the next clk for N ce cycles.
- With N=0, holdoff_o stays low.
REQ-024 dead_o is registered and high when the next-cycle occupancy is at least FIFO_DEPTH-1. This guarantees that a trigger already in flight (the L2 registers holdoff/dead one cycle) is always stored.
REQ-025 Output stream, AXI4-Stream semantics:
- m_evt_tvalid_o is high while occupancy > 0;
- a transfer occurs when tvalid=1 and tready=1, and pops one entry;
- tdata is stable while tvalid=1 and tready=0;
- the output order is FIFO order.
REQ-026 Latency: an accepted trigger into an empty FIFO produces m_evt_tvalid_o=1 on the next clk edge (1-cycle latency).
REQ-027 A simultaneous write and read keeps occupancy unchanged, including at occupancy 0 or full.
- At occupancy 0 there is no bypass: the read side is not valid, so only the write occurs.
- At full, the write is permitted because the read frees a slot in the same cycle.
REQ-028 Occupancy counter width is clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 A run_i falling edge neither flushes buffered events nor resets the counters; the buffer continues to drain.

Reset
REQ-030 On rst_i=1, the following are cleared:
- FIFO occupancy and pointers to 0;
- m_evt_tvalid_o=0;
- both counters to 0;
- holdoff counter to 0;
- dropped_o=0;
- dead_o=0.
REQ-031 During rst_i=1, holdoff_o=1; after reset it follows REQ-023.
REQ-032 rst_i mid-operation discards buffered events and any in-progress holdoff within one clk; a trigger in the same cycle as rst_i=1 is not accepted.
REQ-033 Run-edge detection register resets to 0, so run_i=1 at reset release counts as a rising edge.

Verification
REQ-034 Basic accept: run_i=1, holdoff_len_i=5, tready=1, one trig_i with tio0_meta_i=0x1122334455667788.
- Next clk: tvalid=1, evnum=0, tdata[63:0]=0x1122334455667788.
- holdoff_o high for exactly 5 ce cycles.
REQ-035 Backpressure/dead: FIFO_DEPTH=4, tready=0, holdoff_len_i=0, triggers sent on consecutive ce cycles.
- dead_o rises after the 3rd write.
- The 4th trigger is stored.
- The 5th trigger increments dropped_o to 1.
- Draining yields evnum 0,1,2,3 in order.
REQ-036 Simultaneous push/pop at full with tready=1: occupancy stays at 4 and dropped_o stays at 0.
REQ-037 Run gating: with run_i=0, 10 triggers give no writes, dropped_o=0 and holdoff_o=1. After a run_i rising edge, the next trigger has evnum=0 and trigtime reflecting a counter cleared at the edge.
REQ-038 Reset mid-stream: with 3 buffered events, a 1-clk rst_i pulse gives tvalid=0, dead_o=0, dropped_o=0 on the next clk; the next accepted event has evnum=0.
REQ-039 Wrap: with the trigtime counter forced near 0xFFFFFFFF (long run or preload), events straddling the wrap show trigtime 0xFFFFFFFF followed by 0x00000000+k.

Source files
------------

// File: rtl/pueo_trig_accept.sv
// L2 trigger acceptance: stamps accepted triggers with event number and trigger time,
// buffers them in a small FIFO and feeds holdoff/dead status back to the L2 trigger.
module pueo_trig_accept #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned HOLDOFF_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic                    run_i,
  input  logic                    trig_i,
  input  logic [63:0]             tio0_meta_i,
  input  logic [63:0]             tio1_meta_i,
  input  logic [63:0]             tio2_meta_i,
  input  logic [63:0]             tio3_meta_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_len_i,
  output logic                    holdoff_o,
  output logic                    dead_o,
  output logic [319:0]            m_evt_tdata_o,
  output logic                    m_evt_tvalid_o,
  input  logic                    m_evt_tready_i,
  output logic [15:0]             dropped_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth     = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] DeadLevel = CntW'(FIFO_DEPTH - 1);

  logic [319:0]            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic [31:0]             trigtime_q, trigtime_d, trigtime_cur;
  logic [31:0]             evnum_q, evnum_d, evnum_cur;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic [15:0]             dropped_q, dropped_d;
  logic                    run_q, holdoff_q, dead_q;
  logic                    run_rise, full, pop, trig_req, push;

  always_comb begin
    run_rise     = run_i & ~run_q;
    // A run rising edge restarts both counters in the edge cycle itself.
    trigtime_cur = run_rise ? 32'd0 : trigtime_q;
    evnum_cur    = run_rise ? 32'd0 : evnum_q;

    full     = (count_q == Depth);
    pop      = (count_q != '0) & m_evt_tready_i;
    trig_req = trig_i & ce_i & run_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push     = trig_req & (~full | pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    trigtime_d = trigtime_cur + 32'(ce_i);
    evnum_d    = evnum_cur + 32'(push);

    dropped_d = dropped_q;
    if (trig_req && !push && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    hold_d = hold_q;
    if (push) begin
      hold_d = holdoff_len_i;
    end else if (ce_i && (hold_q != '0)) begin
      hold_d = hold_q - HOLDOFF_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      trigtime_q <= '0;
      evnum_q    <= '0;
      hold_q     <= '0;
      dropped_q  <= '0;
      run_q      <= 1'b0;
      holdoff_q  <= 1'b1;
      dead_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      trigtime_q <= trigtime_d;
      evnum_q    <= evnum_d;
      hold_q     <= hold_d;
      dropped_q  <= dropped_d;
      run_q      <= run_i;
      holdoff_q  <= (hold_d != '0) | ~run_i;
      // One slot of headroom covers a trigger already in flight in the L2.
      dead_q     <= (count_d >= DeadLevel);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= {evnum_cur, trigtime_cur, tio3_meta_i, tio2_meta_i, tio1_meta_i,
                          tio0_meta_i};
    end
  end

  assign m_evt_tdata_o  = mem_q[rd_ptr_q];
  assign m_evt_tvalid_o = (count_q != '0);
  assign holdoff_o      = holdoff_q;
  assign dead_o         = dead_q;
  assign dropped_o      = dropped_q;

endmodule

// File: tb/tb_pueo_trig_accept.sv
// Bench for pueo_trig_accept: directed scenarios plus random traffic, checked every cycle
// against a queue-based event model.
module tb_pueo_trig_accept;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, ce, run, trig, tready;
  logic [63:0]  meta0, meta1, meta2, meta3;
  logic [15:0]  len;
  logic         holdoff_o, dead_o, m_evt_tvalid_o;
  logic [319:0] m_evt_tdata_o;
  logic [15:0]  dropped_o;

  always #5 clk = ~clk;

  pueo_trig_accept #(
    .FIFO_DEPTH  (DEPTH),
    .HOLDOFF_BITS(16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ce_i          (ce),
    .run_i         (run),
    .trig_i        (trig),
    .tio0_meta_i   (meta0),
    .tio1_meta_i   (meta1),
    .tio2_meta_i   (meta2),
    .tio3_meta_i   (meta3),
    .holdoff_len_i (len),
    .holdoff_o     (holdoff_o),
    .dead_o        (dead_o),
    .m_evt_tdata_o (m_evt_tdata_o),
    .m_evt_tvalid_o(m_evt_tvalid_o),
    .m_evt_tready_i(tready),
    .dropped_o     (dropped_o)
  );

  // Reference model state
  logic [319:0] mq[$];
  logic [31:0]  m_tt, m_en;
  int unsigned  m_hold, m_drop;
  bit           m_holdoff, m_dead, m_runp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise, pop, acc;
    logic [31:0] tt, en;
    if (rst) begin
      mq.delete();
      m_tt = 0; m_en = 0; m_hold = 0; m_drop = 0;
      m_holdoff = 1'b1; m_dead = 1'b0; m_runp = 1'b0;
      return;
    end
    rise = run && !m_runp;
    tt   = rise ? 32'd0 : m_tt;
    en   = rise ? 32'd0 : m_en;
    pop  = (mq.size() > 0) && tready;
    acc  = 1'b0;
    if (trig && ce && run) begin
      if (mq.size() < DEPTH || pop) acc = 1'b1;
      else if (m_drop < 65535) m_drop++;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({en, tt, meta3, meta2, meta1, meta0});
      en = en + 32'd1;
      m_hold = len;
    end else if (ce && m_hold > 0) begin
      m_hold--;
    end
    m_tt      = tt + 32'(ce);
    m_en      = en;
    m_holdoff = (m_hold != 0) || !run;
    m_dead    = mq.size() >= DEPTH - 1;
    m_runp    = run;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("tvalid", 320'(m_evt_tvalid_o), 320'(mq.size() > 0));
    if (mq.size() > 0) chk("tdata", m_evt_tdata_o, mq[0]);
    chk("holdoff", 320'(holdoff_o), 320'(m_holdoff));
    chk("dead", 320'(dead_o), 320'(m_dead));
    chk("dropped", 320'(dropped_o), 320'(m_drop[15:0]));
  endtask

  task automatic rand_meta();
    meta0 = {$urandom, $urandom};
    meta1 = {$urandom, $urandom};
    meta2 = {$urandom, $urandom};
    meta3 = {$urandom, $urandom};
  endtask

  initial begin
    int hcnt;
    int vcnt;
    logic [31:0] wrap_exp[3];
    rst = 1'b1; ce = 1'b1; run = 1'b0; trig = 1'b0; tready = 1'b1; len = 16'd5;
    meta0 = '0; meta1 = '0; meta2 = '0; meta3 = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_holdoff", 320'(holdoff_o), 320'(1));
    chk("rst_tvalid", 320'(m_evt_tvalid_o), 320'(0));

    // Basic accept with 5-cycle holdoff
    rst = 1'b0; run = 1'b1;
    cyc();
    rand_meta();
    meta0 = 64'h1122_3344_5566_7788;
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    chk("basic_tvalid", 320'(m_evt_tvalid_o), 320'(1));
    chk("basic_evnum", 320'(m_evt_tdata_o[319:288]), 320'(0));
    chk("basic_meta0", 320'(m_evt_tdata_o[63:0]), 320'(64'h1122_3344_5566_7788));
    hcnt = int'(holdoff_o);
    repeat (9) begin
      cyc();
      hcnt += int'(holdoff_o);
    end
    chk("holdoff_cycles", 320'(hcnt), 320'(5));

    // Backpressure / dead / drop after a fresh run edge
    run = 1'b0;
    cyc();
    run = 1'b1;
    cyc();
    tready = 1'b0; len = 16'd0;
    for (int k = 0; k < 5; k++) begin
      trig = 1'b1;
      rand_meta();
      cyc();
      if (k == 1) chk("dead_after2", 320'(dead_o), 320'(0));
      if (k == 2) chk("dead_after3", 320'(dead_o), 320'(1));
      if (k == 4) chk("dropped_5th", 320'(dropped_o), 320'(1));
    end
    trig = 1'b0;
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_evnum", 320'(m_evt_tdata_o[319:288]), 320'(k));
      cyc();
    end
    chk("drained", 320'(m_evt_tvalid_o), 320'(0));

    // Simultaneous push/pop at full
    tready = 1'b0;
    repeat (4) begin
      trig = 1'b1;
      rand_meta();
      cyc();
    end
    tready = 1'b1;
    repeat (3) begin
      rand_meta();
      cyc();
    end
    trig = 1'b0;
    chk("pp_dropped", 320'(dropped_o), 320'(1));
    chk("pp_dead", 320'(dead_o), 320'(1));
    vcnt = 0;
    repeat (6) begin
      vcnt += int'(m_evt_tvalid_o);
      cyc();
    end
    chk("pp_occupancy", 320'(vcnt), 320'(4));

    // Run gating
    run = 1'b0;
    repeat (10) begin
      trig = 1'b1;
      rand_meta();
      cyc();
    end
    trig = 1'b0;
    chk("gate_dropped", 320'(dropped_o), 320'(1));
    chk("gate_holdoff", 320'(holdoff_o), 320'(1));
    chk("gate_tvalid", 320'(m_evt_tvalid_o), 320'(0));
    run = 1'b1; ce = 1'b1;
    cyc();
    ce = 1'b0;
    cyc();
    ce = 1'b1; trig = 1'b1;
    rand_meta();
    cyc();
    trig = 1'b0;
    chk("gate_evnum", 320'(m_evt_tdata_o[319:288]), 320'(0));
    chk("gate_trigtime", 320'(m_evt_tdata_o[287:256]), 320'(1));
    cyc();

    // Reset mid-stream
    tready = 1'b0;
    repeat (3) begin
      trig = 1'b1;
      rand_meta();
      cyc();
    end
    chk("pre_rst_dead", 320'(dead_o), 320'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0; trig = 1'b0;
    chk("rst_mid_tvalid", 320'(m_evt_tvalid_o), 320'(0));
    chk("rst_mid_dead", 320'(dead_o), 320'(0));
    chk("rst_mid_dropped", 320'(dropped_o), 320'(0));
    cyc();
    trig = 1'b1;
    rand_meta();
    cyc();
    trig = 1'b0;
    chk("rst_mid_evnum", 320'(m_evt_tdata_o[319:288]), 320'(0));
    tready = 1'b1;
    cyc();
    cyc();

    // Trigger-time wrap
    tready = 1'b0;
    force dut.trigtime_q = 32'hFFFF_FFFE;
    m_tt = 32'hFFFF_FFFE;
    #1;
    release dut.trigtime_q;
    repeat (3) begin
      trig = 1'b1;
      rand_meta();
      cyc();
    end
    trig = 1'b0;
    tready = 1'b1;
    wrap_exp[0] = 32'hFFFF_FFFE;
    wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      chk("wrap_trigtime", 320'(m_evt_tdata_o[287:256]), 320'(wrap_exp[k]));
      cyc();
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      ce     = 1'($urandom_range(0, 1));
      trig   = ($urandom_range(0, 9) < 4);
      tready = ($urandom_range(0, 9) < 6);
      len    = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) run = ~run;
      rand_meta();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
